// File: rtl/dd_led_rx.sv
// One-wire LED stream receiver: measures high-pulse widths, recovers MSB-first pixel
// words, presents them on a valid/ready port and reports frame latches and line errors.
module dd_led_rx #(
    parameter int N_LEDS       = 64,
    parameter int BITS_PER_LED = 24,
    parameter int T_GLITCH     = 10,
    parameter int T_THRESH     = 60,
    parameter int T_STUCK      = 200,
    parameter int T_RESET      = 5000,
    localparam int IDX_W       = $clog2(N_LEDS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    data_rx,
    output logic [BITS_PER_LED-1:0] pixel_data,
    output logic [IDX_W-1:0]        pixel_index,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic                    frame_done,
    output logic [15:0]             frame_count,
    output logic [IDX_W:0]          pixels_in_frame,
    output logic                    err_short,
    output logic                    err_stuck,
    output logic                    err_partial,
    output logic                    err_overflow,
    output logic                    err_excess,
    input  logic                    err_clear
);

    localparam int CNT_W = $clog2(T_RESET + 1);
    localparam int BIT_W = $clog2(BITS_PER_LED + 1);
    localparam int PIX_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GLITCH_C    = CNT_W'(T_GLITCH);
    localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] STUCK_LAST  = CNT_W'(T_STUCK - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(T_RESET - 1);
    localparam logic [BIT_W-1:0] BITS_LAST   = BIT_W'(BITS_PER_LED - 1);
    localparam logic [PIX_W-1:0] PIX_LIMIT   = PIX_W'(N_LEDS);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    // Sticky flag update: a new set event takes priority over a clear in the same cycle.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

    logic                    sync1_q, sync2_q, prev_q;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic [BITS_PER_LED-1:0] data_q, data_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic                    valid_q, valid_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [PIX_W-1:0]        pif_q, pif_d;
    logic                    short_q, short_d, stuck_q, stuck_d, partial_q, partial_d;
    logic                    over_q, over_d, excess_q, excess_d;

    logic                    line_s, rise_s, fall_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    word_done_s, load_s, latch_s;
    logic                    set_short_s, set_stuck_s, set_partial_s, set_over_s, set_excess_s;

    assign line_s    = sync2_q;
    assign rise_s    = sync2_q & ~prev_q;
    assign fall_s    = ~sync2_q & prev_q;
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Line decoder: width measurement, bit recovery and frame/latch tracking.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_done_s   = 1'b0;
        latch_s       = 1'b0;
        set_short_s   = 1'b0;
        set_stuck_s   = 1'b0;
        set_partial_s = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (line_s) begin
                    cnt_d = '0;
                end else if (cnt_q >= RESET_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    if (cnt_q < GLITCH_C) begin
                        set_short_s = 1'b1;
                        state_d     = ST_SYNC;
                        cnt_d       = '0;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                    end else begin
                        shift_d = {shift_q[BITS_PER_LED-2:0], (cnt_q >= THRESH_C)};
                        state_d = ST_LOW;
                        cnt_d   = CNT_ONE;
                        if (bit_cnt_q == BITS_LAST) begin
                            word_done_s = 1'b1;
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else if (cnt_q >= STUCK_LAST) begin
                    set_stuck_s = 1'b1;
                    state_d     = ST_SYNC;
                    cnt_d       = '0;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= RESET_LAST) begin
                    latch_s       = 1'b1;
                    set_partial_s = (bit_cnt_q != '0);
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    shift_d       = '0;
                    bit_cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register, pixel accounting, frame statistics and sticky error flags.
    always_comb begin
        load_s       = word_done_s && (pix_cnt_q < PIX_LIMIT);
        set_excess_s = word_done_s && !(pix_cnt_q < PIX_LIMIT);
        set_over_s   = load_s && valid_q && !pixel_ready;
        data_d       = data_q;
        index_d      = index_q;
        valid_d      = valid_q;
        pix_cnt_d    = pix_cnt_q;
        if (latch_s) begin
            pix_cnt_d = '0;
        end else if (load_s) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
        if (load_s) begin
            data_d  = shift_d;
            index_d = pix_cnt_q[IDX_W-1:0];
            valid_d = 1'b1;
        end else if (valid_q && pixel_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        frame_done_d  = latch_s;
        frame_count_d = latch_s ? frame_count_q + 16'd1 : frame_count_q;
        pif_d         = latch_s ? pix_cnt_q : pif_q;
        short_d       = sticky_next(short_q,   set_short_s,   err_clear);
        stuck_d       = sticky_next(stuck_q,   set_stuck_s,   err_clear);
        partial_d     = sticky_next(partial_q, set_partial_s, err_clear);
        over_d        = sticky_next(over_q,    set_over_s,    err_clear);
        excess_d      = sticky_next(excess_q,  set_excess_s,  err_clear);
    end

    // State registers, including the two-flop synchronizer and edge-detect stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            state_q       <= ST_SYNC;
            cnt_q         <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            data_q        <= '0;
            index_q       <= '0;
            valid_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            pif_q         <= '0;
            short_q       <= 1'b0;
            stuck_q       <= 1'b0;
            partial_q     <= 1'b0;
            over_q        <= 1'b0;
            excess_q      <= 1'b0;
        end else begin
            sync1_q       <= data_rx;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            data_q        <= data_d;
            index_q       <= index_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            pif_q         <= pif_d;
            short_q       <= short_d;
            stuck_q       <= stuck_d;
            partial_q     <= partial_d;
            over_q        <= over_d;
            excess_q      <= excess_d;
        end
    end

    assign pixel_data      = data_q;
    assign pixel_index     = index_q;
    assign pixel_valid     = valid_q;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign pixels_in_frame = pif_q;
    assign err_short       = short_q;
    assign err_stuck       = stuck_q;
    assign err_partial     = partial_q;
    assign err_overflow    = over_q;
    assign err_excess      = excess_q;

endmodule

// File: tb/tb_dd_led_rx.sv
// Directed bench for dd_led_rx with time constants scaled down (1 bit = 8/4 high, 12-cycle period)
// so a full 64-pixel frame fits a short run; expected values are hand-derived.
module tb_dd_led_rx;

    localparam int NL = 64;
    localparam int TG = 3;
    localparam int TT = 6;
    localparam int TS = 20;
    localparam int TR = 500;
    localparam int IW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          data_rx;
    logic [23:0]   pixel_data;
    logic [IW-1:0] pixel_index;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [IW:0]   pixels_in_frame;
    logic          err_short, err_stuck, err_partial, err_overflow, err_excess;
    logic          err_clear;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            fd_cnt = 0;
    int            ready_mode = 1;
    logic [31:0]   acc_q[$];

    dd_led_rx #(
        .N_LEDS(NL), .BITS_PER_LED(24), .T_GLITCH(TG), .T_THRESH(TT),
        .T_STUCK(TS), .T_RESET(TR)
    ) u_dut (
        .clock(clock), .reset(reset), .data_rx(data_rx),
        .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .frame_done(frame_done), .frame_count(frame_count),
        .pixels_in_frame(pixels_in_frame), .err_short(err_short), .err_stuck(err_stuck),
        .err_partial(err_partial), .err_overflow(err_overflow), .err_excess(err_excess),
        .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    // Consumer-side monitor: records accepted pixels and frame_done pulses.
    always @(negedge clock) begin
        if (!reset && pixel_valid && pixel_ready)
            acc_q.push_back({2'b00, pixel_index, pixel_data});
        if (!reset && frame_done)
            fd_cnt <= fd_cnt + 1;
    end

    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0:       pixel_ready = 1'b0;
                1:       pixel_ready = 1'b1;
                default: pixel_ready = ~pixel_ready;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        data_rx = v;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            hold(1'b1, w[i] ? 8 : 4);
            hold(1'b0, w[i] ? 4 : 8);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clock);
        #2;
        err_clear = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        reset = 1'b1;
        data_rx = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(posedge clock);
        sample();
        check("rst_valid", {31'd0, pixel_valid}, 32'd0);
        check("rst_data", {8'd0, pixel_data}, 32'd0);
        check("rst_fcount", {16'd0, frame_count}, 32'd0);
        check("rst_errs", {27'd0, err_short, err_stuck, err_partial, err_overflow, err_excess}, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Single pixel frame
        hold(1'b0, TR + 10);
        send_bits(24'hA5C33C, 24);
        hold(1'b0, TR + 20);
        sample();
        check("t1_count", acc_q.size(), 32'd1);
        if (acc_q.size() > 0) check("t1_pix", acc_q[0], 32'h00A5C33C);
        check("t1_fd", fd_cnt, 32'd1);
        check("t1_fcount", {16'd0, frame_count}, 32'd1);
        check("t1_pif", {25'd0, pixels_in_frame}, 32'd1);
        check("t1_errs", {27'd0, err_short, err_stuck, err_partial, err_overflow, err_excess}, 32'd0);

        // Full frame, ready toggling
        acc_q.delete();
        ready_mode = 2;
        for (int w = 0; w < 64; w++) send_bits(24'(w), 24);
        hold(1'b0, TR + 20);
        sample();
        check("t2_count", acc_q.size(), 32'd64);
        for (int i = 0; i < 64 && i < acc_q.size(); i++) begin
            e = {8'h00, 24'(i)};
            e[29:24] = 6'(i);
            check("t2_pix", acc_q[i], e);
        end
        check("t2_pif", {25'd0, pixels_in_frame}, 32'd64);
        check("t2_over", {31'd0, err_overflow}, 32'd0);
        check("t2_fcount", {16'd0, frame_count}, 32'd2);

        // 65-word frame
        acc_q.delete();
        ready_mode = 1;
        for (int w = 0; w < 65; w++) send_bits(24'h000100 + 24'(w), 24);
        hold(1'b0, TR + 20);
        sample();
        check("t3_count", acc_q.size(), 32'd64);
        if (acc_q.size() > 63) begin
            check("t3_first", acc_q[0], 32'h00000100);
            check("t3_last", acc_q[63], 32'h3F00013F);
        end
        check("t3_excess", {31'd0, err_excess}, 32'd1);
        check("t3_valid", {31'd0, pixel_valid}, 32'd0);
        check("t3_pif", {25'd0, pixels_in_frame}, 32'd64);
        check("t3_over", {31'd0, err_overflow}, 32'd0);
        pulse_clear();
        sample();
        check("t3_clear", {31'd0, err_excess}, 32'd0);

        // Glitch after 10 bits, resync, then a clean word
        acc_q.delete();
        send_bits(24'h0002AD, 10);
        hold(1'b1, 2);
        hold(1'b0, 8);
        sample();
        check("t4_short", {31'd0, err_short}, 32'd1);
        send_bits(24'h000016, 5);
        hold(1'b0, 20);
        sample();
        check("t4_nopix", acc_q.size(), 32'd0);
        hold(1'b0, TR + 10);
        send_bits(24'h123456, 24);
        hold(1'b0, 20);
        sample();
        check("t4_count", acc_q.size(), 32'd1);
        if (acc_q.size() > 0) check("t4_pix", acc_q[0], 32'h00123456);
        check("t4_fd", fd_cnt, 32'd3);
        hold(1'b0, TR + 20);
        sample();
        check("t4_fcount", {16'd0, frame_count}, 32'd4);
        check("t4_pif", {25'd0, pixels_in_frame}, 32'd1);
        pulse_clear();
        sample();
        check("t4_clear", {31'd0, err_short}, 32'd0);

        // Overflow with ready held low
        acc_q.delete();
        ready_mode = 0;
        send_bits(24'hABCDEF, 24);
        send_bits(24'h654321, 24);
        hold(1'b0, 20);
        sample();
        check("t5_over", {31'd0, err_overflow}, 32'd1);
        check("t5_valid", {31'd0, pixel_valid}, 32'd1);
        check("t5_data", {8'd0, pixel_data}, 32'h00654321);
        check("t5_index", {26'd0, pixel_index}, 32'd1);
        ready_mode = 1;
        hold(1'b0, 10);
        sample();
        check("t5_count", acc_q.size(), 32'd1);
        if (acc_q.size() > 0) check("t5_pix", acc_q[0], 32'h01654321);
        hold(1'b0, TR + 20);
        sample();
        check("t5_fcount", {16'd0, frame_count}, 32'd5);
        check("t5_pif", {25'd0, pixels_in_frame}, 32'd2);
        pulse_clear();
        sample();
        check("t5_clear", {31'd0, err_overflow}, 32'd0);

        // Partial word at latch, stuck-high line, reset mid-word
        send_bits(24'h000ABC, 12);
        hold(1'b0, TR + 20);
        sample();
        check("t6_partial", {31'd0, err_partial}, 32'd1);
        check("t6_fd", fd_cnt, 32'd6);
        check("t6_fcount", {16'd0, frame_count}, 32'd6);
        check("t6_pif", {25'd0, pixels_in_frame}, 32'd0);
        hold(1'b1, TS + 5);
        hold(1'b0, 5);
        sample();
        check("t6_stuck", {31'd0, err_stuck}, 32'd1);
        hold(1'b0, TR + 10);
        send_bits(24'h0000F0, 8);
        reset = 1'b1;
        sample();
        check("t6_rst_errs", {27'd0, err_short, err_stuck, err_partial, err_overflow, err_excess}, 32'd0);
        check("t6_rst_fcount", {16'd0, frame_count}, 32'd0);
        check("t6_rst_out", {6'd0, pixel_valid, frame_done, pixels_in_frame, pixel_index, 10'd0}, 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dd_led_rx.md
Name: dd_led_rx

Overview:
- One-wire LED stream receiver/decoder. It is the far end of the arm LED transmit line (data_tx).
- Measures high-pulse widths on the serial line and recovers bits. Assembles MSB-first 24-bit pixel words and presents them on a valid/ready interface with a pixel index.
- Detects the low "latch/reset" gap as the frame boundary.
- Used as the on-board loopback checker and as the strip model in system benches.

Parameters:
- N_LEDS, 64, pixels expected per frame (both sides of one strip); index width IDX_W = $clog2(N_LEDS).
- BITS_PER_LED, 24, bits per pixel word.
- T_GLITCH, 10, high pulses shorter than this many cycles are errors.
- T_THRESH, 60, high width >= T_THRESH decodes as 1, otherwise 0.
- T_STUCK, 200, high width reaching this count is a stuck-high error.
- T_RESET, 5000, consecutive low cycles that end a frame (latch).

Ports:
- clock  in  1  system clock (100 MHz nominal)
- reset  in  1  asynchronous, active-high reset
- data_rx  in  1  asynchronous serial line from the LED driver
- pixel_data  out  BITS_PER_LED  decoded pixel word, MSB = first received bit
- pixel_index  out  IDX_W  position of pixel_data within the current frame
- pixel_valid  out  1  pixel_data/pixel_index valid
- pixel_ready  in  1  consumer accepts the pixel when high with pixel_valid
- frame_done  out  1  one-cycle pulse at each latch gap
- frame_count  out  16  number of completed frames, wraps modulo 2^16
- pixels_in_frame  out  IDX_W+1  pixel count of the last completed frame, captured at frame_done
- err_short  out  1  sticky: glitch pulse seen
- err_stuck  out  1  sticky: line high >= T_STUCK
- err_partial  out  1  sticky: latch arrived with a partial word
- err_overflow  out  1  sticky: a pixel was overwritten before acceptance
- err_excess  out  1  sticky: more than N_LEDS pixels in one frame
- err_clear  in  1  synchronous clear of all sticky error flags

Behaviour:
- Reset values: all outputs 0; state = SYNC; counters, shift register and pixel index are 0.
- Input path: data_rx passes through a 2-flop synchronizer plus 1 edge-detect register. Edge decisions therefore lag the pin by 3 cycles; widths are measured on the synchronized signal.
- SYNC state: counts consecutive low cycles.
  - Any high restarts the count.
  - The count reaching T_RESET moves to IDLE, with no frame_done.
  - Purpose: the receiver never locks mid-frame.
- IDLE state: a rising edge enters HIGH with high_cnt = 1.
- HIGH state: high_cnt increments each cycle.
  - high_cnt reaching T_STUCK: set err_stuck, discard the partial word, go to SYNC.
  - Falling edge with high_cnt < T_GLITCH: set err_short, discard the partial word, go to SYNC.
  - Other falling edges: shift in bit (high_cnt >= T_THRESH), bit_cnt++, enter LOW with low_cnt = 1.
- LOW state: low_cnt increments each cycle.
  - Rising edge goes to HIGH, with high_cnt = 1.
  - low_cnt reaching T_RESET is a latch:
    - if bit_cnt != 0, set err_partial and discard the bits;
    - pulse frame_done, frame_count++, pixels_in_frame = pixel count;
    - clear bit_cnt and the pixel count; go to IDLE.
- Counter widths are sized to hold T_RESET. Counters saturate, never wrap.
- Word completion happens when bit_cnt reaches BITS_PER_LED on a falling-edge decision. The output register updates the cycle after that decision.
  - If pixel count < N_LEDS: load pixel_data and pixel_index = pixel count; set pixel_valid; pixel count++; bit_cnt = 0.
  - If pixel_valid is still high and pixel_ready is low at load time: set err_overflow. The new word overwrites and pixel_valid stays high.
  - If pixel count >= N_LEDS: set err_excess and drop the word. The count saturates at N_LEDS and is not incremented.
- Handshake: pixel_valid stays high, with stable data, until pixel_valid && pixel_ready. It clears the cycle after acceptance unless a new word loads in that same cycle (the load wins and pixel_valid stays high).
- Sticky errors: err_clear clears all sticky flags. If a set and err_clear coincide in the same cycle, the set wins.
- Latch with a pending unaccepted pixel: pixel_valid is held. frame_done does not disturb the output register.
- Reset asserted mid-operation: all state returns immediately to reset values. Any pending pixel is lost.

Test Plan:
- Reset, then 5000 low cycles, then 24 pulses with highs of 80/40 cycles and 125-cycle bit periods encoding 0xA5C33C, then 5000 low cycles with pixel_ready held 1 -> exactly one pixel_valid with pixel_data=0xA5C33C, pixel_index=0; frame_done pulse; frame_count=1; pixels_in_frame=1; no errors.
- Full frame of 64 incrementing words (0x000000..0x00003F), then latch, with pixel_ready toggling 1/0 every cycle -> 64 accepted pixels, indices 0..63 in order; pixels_in_frame=64; err_overflow=0.
- Frame of 65 words -> first 64 delivered; err_excess=1; 65th word not presented; err_clear pulse -> err_excess=0.
- 5-cycle high pulse after 10 valid bits -> err_short=1; no pixel emitted. After the line rises, the next valid bits are not decoded until 5000 low cycles elapse; then a full word decodes correctly.
- pixel_ready held 0 across two completed words -> err_overflow=1; pixel_data equals the second word; pixel_index=1.
- 12 bits then latch -> err_partial=1 and frame_done pulses; line high for 200 cycles -> err_stuck=1; reset asserted mid-word -> all outputs 0 on the next edge.
